// File: rtl/ttpu_pkg.sv
// Shared TTPU types and sizes: RAM geometry, loader FSM states and the frame header record.
package ttpu_pkg;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 16;
    localparam int RAM_DEPTH = 2048;
    localparam int MAX_DIM   = 16;

    typedef enum logic [2:0] {
        IDLE,
        DIM,
        LOAD,
        DONE,
        ERR
    } loader_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] base;
        logic [4:0]        rows;
        logic [4:0]        cols;
    } frame_hdr_t;

endpackage

// File: rtl/ram_stream_hdr_check.sv
// Combinational frame header validation: dimension limits and, when RAM_STREAM_LOADER_BOUNDS_CHECK_EN
// is defined, that the frame fits inside RAM_DEPTH words (otherwise range_ok is tied high).
module ram_stream_hdr_check #(
    parameter int ADDR_W    = ttpu_pkg::ADDR_W,
    parameter int RAM_DEPTH = ttpu_pkg::RAM_DEPTH,
    parameter int MAX_DIM   = ttpu_pkg::MAX_DIM
) (
    input  logic [ADDR_W-1:0] base,
    input  logic [7:0]        rows,
    input  logic [7:0]        cols,
    output logic              dims_ok,
    output logic              range_ok
);

    assign dims_ok = (rows != 8'd0) && (cols != 8'd0) &&
                     (rows <= 8'(MAX_DIM)) && (cols <= 8'(MAX_DIM));

`ifdef RAM_STREAM_LOADER_BOUNDS_CHECK_EN
    // Wide enough that base + 255*255 never truncates.
    localparam int SPAN_W = ADDR_W + 17;
    logic [SPAN_W-1:0] frame_end;

    assign frame_end = SPAN_W'(base) + SPAN_W'(rows) * SPAN_W'(cols);
    assign range_ok  = (frame_end <= SPAN_W'(RAM_DEPTH));
`else
    localparam int unused_depth = RAM_DEPTH;
    logic unused_base;

    assign unused_base = ^base;
    assign range_ok    = 1'b1;
`endif

endmodule

// File: rtl/ram_stream_loader.sv
// Framed valid/ready word stream to single-word RAM writes; publishes the last good frame's header.
// Optional range check in the header checker is enabled by RAM_STREAM_LOADER_BOUNDS_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for word 0 (base address)
// DIM   | waiting for word 1 ({rows, cols})
// LOAD  | accepting rows*cols payload words
// DONE  | one-cycle frame completion, done pulse
// ERR   | bad header, waits for err_clear
module ram_stream_loader #(
    parameter int DATA_W    = ttpu_pkg::DATA_W,
    parameter int ADDR_W    = ttpu_pkg::ADDR_W,
    parameter int RAM_DEPTH = ttpu_pkg::RAM_DEPTH,
    parameter int MAX_DIM   = ttpu_pkg::MAX_DIM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              err_clear,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] frame_base,
    output logic [4:0]        frame_rows,
    output logic [4:0]        frame_cols
);

    ttpu_pkg::loader_state_t state_q, state_d;
    ttpu_pkg::frame_hdr_t    hdr_q;

    logic [8:0] remaining_q;
    logic [8:0] k_q;
    logic       xfer;
    logic       dims_ok;
    logic       range_ok;
    logic       take_base;
    logic       take_dims;
    logic       take_word;
    logic       last_word;

    assign xfer      = s_valid && s_ready;
    assign last_word = (remaining_q == 9'd1);

    ram_stream_hdr_check #(
        .ADDR_W    (ADDR_W),
        .RAM_DEPTH (RAM_DEPTH),
        .MAX_DIM   (MAX_DIM)
    ) u_hdr_check (
        .base     (hdr_q.base),
        .rows     (s_data[15:8]),
        .cols     (s_data[7:0]),
        .dims_ok  (dims_ok),
        .range_ok (range_ok)
    );

    always_comb begin
        state_d   = state_q;
        take_base = 1'b0;
        take_dims = 1'b0;
        take_word = 1'b0;
        unique case (state_q)
            ttpu_pkg::IDLE: begin
                if (xfer) begin
                    take_base = 1'b1;
                    state_d   = ttpu_pkg::DIM;
                end
            end
            ttpu_pkg::DIM: begin
                if (xfer) begin
                    if (dims_ok && range_ok) begin
                        take_dims = 1'b1;
                        state_d   = ttpu_pkg::LOAD;
                    end else begin
                        state_d   = ttpu_pkg::ERR;
                    end
                end
            end
            ttpu_pkg::LOAD: begin
                if (xfer) begin
                    take_word = 1'b1;
                    if (last_word) state_d = ttpu_pkg::DONE;
                end
            end
            ttpu_pkg::DONE: state_d = ttpu_pkg::IDLE;
            ttpu_pkg::ERR: begin
                if (err_clear) state_d = ttpu_pkg::IDLE;
            end
            default: state_d = ttpu_pkg::IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ttpu_pkg::IDLE;
            hdr_q       <= '0;
            remaining_q <= '0;
            k_q         <= '0;
            s_ready     <= 1'b0;
            ram_write   <= 1'b0;
            ram_address <= '0;
            ram_data    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            frame_base  <= '0;
            frame_rows  <= '0;
            frame_cols  <= '0;
        end else begin
            state_q   <= state_d;
            s_ready   <= (state_d == ttpu_pkg::IDLE) || (state_d == ttpu_pkg::DIM) ||
                         (state_d == ttpu_pkg::LOAD);
            busy      <= (state_d == ttpu_pkg::DIM) || (state_d == ttpu_pkg::LOAD);
            done      <= (state_d == ttpu_pkg::DONE);
            error     <= (state_d == ttpu_pkg::ERR);
            ram_write <= take_word;

            if (take_base) hdr_q.base <= ADDR_W'(s_data);

            if (take_dims) begin
                hdr_q.rows  <= s_data[12:8];
                hdr_q.cols  <= s_data[4:0];
                remaining_q <= 9'(s_data[15:8]) * 9'(s_data[7:0]);
                k_q         <= '0;
            end

            if (take_word) begin
                ram_address <= hdr_q.base + ADDR_W'(k_q);
                ram_data    <= s_data;
                k_q         <= k_q + 9'd1;
                remaining_q <= remaining_q - 9'd1;
                if (last_word) begin
                    frame_base <= hdr_q.base;
                    frame_rows <= hdr_q.rows;
                    frame_cols <= hdr_q.cols;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_stream_loader.sv
// Directed bench for ram_stream_loader: table of good frames plus error, bounds, reset and back-to-back sequences.
module tb_ram_stream_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        err_clear;
    logic        ram_write;
    logic [15:0] ram_address;
    logic [15:0] ram_data;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] frame_base;
    logic [4:0]  frame_rows;
    logic [4:0]  frame_cols;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [15:0] wr_addr[$];
    logic [15:0] wr_data[$];
    int          wr_cyc[$];
    int          done_cyc[$];

    typedef struct {
        logic [15:0] base;
        logic [7:0]  rows;
        logic [7:0]  cols;
        logic [15:0] first;
        bit          stall;
    } frame_t;

    frame_t tbl[4];

    always #5 clk = ~clk;

    ram_stream_loader dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .err_clear   (err_clear),
        .ram_write   (ram_write),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .frame_base  (frame_base),
        .frame_rows  (frame_rows),
        .frame_cols  (frame_cols)
    );

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (ram_write) begin
            wr_addr.push_back(ram_address);
            wr_data.push_back(ram_data);
            wr_cyc.push_back(cyc);
        end
        if (done) done_cyc.push_back(cyc);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_cyc.delete();
    endtask

    // Called at a negedge; returns at the negedge after the word has transferred.
    task automatic push(input logic [15:0] w, input bit gap);
        int t;
        if (gap) begin
            s_valid = 1'b0;
            @(negedge clk);
        end
        s_valid = 1'b1;
        s_data  = w;
        t = 0;
        while (!s_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("push_ready", {31'd0, s_ready}, 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, {31'd0, s_ready}, 0);
        check({tag, "_ram_write"}, {31'd0, ram_write}, 0);
        check({tag, "_ram_address"}, {16'd0, ram_address}, 0);
        check({tag, "_ram_data"}, {16'd0, ram_data}, 0);
        check({tag, "_busy"}, {31'd0, busy}, 0);
        check({tag, "_done"}, {31'd0, done}, 0);
        check({tag, "_error"}, {31'd0, error}, 0);
        check({tag, "_frame_base"}, {16'd0, frame_base}, 0);
        check({tag, "_frame_rows"}, {27'd0, frame_rows}, 0);
        check({tag, "_frame_cols"}, {27'd0, frame_cols}, 0);
    endtask

    task automatic run_frame(input frame_t f);
        int n;
        n = int'(f.rows) * int'(f.cols);
        clear_log();
        push(f.base, 1'b0);
        push({f.rows, f.cols}, f.stall);
        for (int k = 0; k < n; k++) push(f.first + 16'(k), f.stall);
        repeat (3) @(negedge clk);
        check("wr_count", wr_addr.size(), n);
        for (int k = 0; k < n && k < wr_addr.size(); k++) begin
            check("wr_addr", {16'd0, wr_addr[k]}, {16'd0, f.base + 16'(k)});
            check("wr_data", {16'd0, wr_data[k]}, {16'd0, f.first + 16'(k)});
        end
        if (!f.stall && wr_cyc.size() == n)
            check("wr_burst", wr_cyc[n-1] - wr_cyc[0], n - 1);
        check("done_count", done_cyc.size(), 1);
        if (done_cyc.size() == 1 && wr_cyc.size() == n)
            check("done_with_last", done_cyc[0], wr_cyc[n-1]);
        check("frame_base", {16'd0, frame_base}, {16'd0, f.base});
        check("frame_rows", {27'd0, frame_rows}, {24'd0, f.rows});
        check("frame_cols", {27'd0, frame_cols}, {24'd0, f.cols});
        check("idle_error", {31'd0, error}, 0);
        check("idle_ready", {31'd0, s_ready}, 1);
        check("idle_busy", {31'd0, busy}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 500000");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{16'h0100, 8'd2,  8'd3, 16'h0001, 1'b0};
        tbl[1] = '{16'h0100, 8'd2,  8'd3, 16'h0001, 1'b1};
        tbl[2] = '{16'h0500, 8'd16, 8'd1, 16'h1000, 1'b0};
        tbl[3] = '{16'h0300, 8'd4,  8'd2, 16'h0040, 1'b1};

        rst = 1'b1; s_valid = 1'b0; s_data = 16'h0000; err_clear = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {31'd0, s_ready}, 1);
        check("busy_after_reset", {31'd0, busy}, 0);

        for (int i = 0; i < 4; i++) run_frame(tbl[i]);

        // Bad header: rows=17
        clear_log();
        push(16'h0200, 1'b0);
        push(16'h1100, 1'b0);
        check("err_error", {31'd0, error}, 1);
        check("err_ready", {31'd0, s_ready}, 0);
        check("err_busy", {31'd0, busy}, 0);
        repeat (3) @(negedge clk);
        check("err_still", {31'd0, error}, 1);
        check("err_writes", wr_addr.size(), 0);
        check("err_done", done_cyc.size(), 0);
        check("err_frame_base", {16'd0, frame_base}, 32'h0300);
        check("err_frame_rows", {27'd0, frame_rows}, 4);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("clr_ready", {31'd0, s_ready}, 1);
        check("clr_error", {31'd0, error}, 0);
        run_frame(tbl[0]);

        // Frame that runs past RAM_DEPTH
`ifdef RAM_STREAM_LOADER_BOUNDS_CHECK_EN
        clear_log();
        push(16'h07F8, 1'b0);
        push(16'h0404, 1'b0);
        repeat (2) @(negedge clk);
        check("bounds_error", {31'd0, error}, 1);
        check("bounds_ready", {31'd0, s_ready}, 0);
        check("bounds_writes", wr_addr.size(), 0);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("bounds_clr_error", {31'd0, error}, 0);
`else
        run_frame('{16'h07F8, 8'd4, 8'd4, 16'h0100, 1'b0});
`endif

        // Reset after 3 of 6 payload words
        clear_log();
        push(16'h0400, 1'b0);
        push(16'h0203, 1'b0);
        push(16'h000A, 1'b0);
        push(16'h000B, 1'b0);
        push(16'h000C, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        check("midrst_writes", wr_addr.size(), 3);
        if (wr_addr.size() == 3) begin
            check("midrst_addr2", {16'd0, wr_addr[2]}, 32'h0402);
            check("midrst_data2", {16'd0, wr_data[2]}, 32'h000C);
        end
        check("midrst_done", done_cyc.size(), 0);
        rst = 1'b0;
        run_frame(tbl[0]);

        // Back-to-back 1x1 frames
        clear_log();
        push(16'h0010, 1'b0);
        push(16'h0101, 1'b0);
        push(16'hAAAA, 1'b0);
        push(16'h0020, 1'b0);
        push(16'h0101, 1'b0);
        push(16'h5555, 1'b0);
        repeat (3) @(negedge clk);
        check("b2b_writes", wr_addr.size(), 2);
        if (wr_addr.size() == 2) begin
            check("b2b_addr0", {16'd0, wr_addr[0]}, 32'h0010);
            check("b2b_data0", {16'd0, wr_data[0]}, 32'hAAAA);
            check("b2b_addr1", {16'd0, wr_addr[1]}, 32'h0020);
            check("b2b_data1", {16'd0, wr_data[1]}, 32'h5555);
        end
        check("b2b_done_count", done_cyc.size(), 2);
        if (done_cyc.size() == 2)
            check("b2b_done_gap", done_cyc[1] - done_cyc[0], 4);
        check("b2b_frame_base", {16'd0, frame_base}, 32'h0020);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
